// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative integer multiply/divide unit (RISC-V M-style ops).
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, with the sign applied on the final step.
// Optional build macro MULDIV_FAST_PATH_EN: divide-by-zero, signed
// overflow and multiply-by-zero bypass the iteration and finish in one cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] md_src0,
    input  logic [WIDTH-1:0] md_src1,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] md_res
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   src0_q, src0_d;   // raw dividend, returned by REM on /0
    logic [WIDTH-1:0]   dvs_q, dvs_d;     // |src1|: multiplicand or divisor
    logic [WIDTH-1:0]   res_q, res_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // {hi, lo}: product, or {remainder, quotient}
    logic               negq_q, negq_d;   // product / quotient is negative
    logic               nega_q, nega_d;   // remainder is negative (sign of src0)
    logic               div0_q, div0_d;

    // Operand signedness and magnitudes of the incoming request.
    logic             s0_sgn, s1_sgn, neg0, neg1;
    logic [WIDTH-1:0] mag0, mag1;
    assign s0_sgn = md_op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    assign s1_sgn = md_op inside {3'd0, 3'd1, 3'd4, 3'd6};
    assign neg0   = s0_sgn & md_src0[WIDTH-1];
    assign neg1   = s1_sgn & md_src1[WIDTH-1];
    assign mag0   = neg0 ? ('0 - md_src0) : md_src0;
    assign mag1   = neg1 ? ('0 - md_src1) : md_src1;

    // One iteration step. Multiply: add multiplicand into hi when lo[0] is
    // set, then shift the whole accumulator right. Divide: shift the next
    // dividend bit into the partial remainder and subtract if it fits.
    logic [WIDTH:0]     mul_sum, div_sh, div_df;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, step_nxt;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_df   = div_sh - {1'b0, dvs_q};
    assign div_nxt  = div_df[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_df[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign step_nxt = op_q[2] ? div_nxt : mul_nxt;

    // Sign fix-up and result selection from the final accumulator value.
    function automatic logic [WIDTH-1:0] finish_res(
        input logic [2:0]       op,
        input logic [2*WIDTH-1:0] acc,
        input logic             negq,
        input logic             nega,
        input logic             div0,
        input logic [WIDTH-1:0] src0
    );
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   quo, rem;
        prod = negq ? ('0 - acc) : acc;
        quo  = negq ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem  = nega ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        case (op)
            3'd0:             finish_res = prod[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: finish_res = prod[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       finish_res = div0 ? '1 : quo;
            default:          finish_res = div0 ? src0 : rem;
        endcase
    endfunction

`ifdef MULDIV_FAST_PATH_EN
    // Detect requests whose result is known without iterating.
    logic             fast, fz1, fovf;
    logic [WIDTH-1:0] fast_res;
    always_comb begin
        fz1      = (md_src1 == '0);
        fovf     = (md_op == 3'd4 || md_op == 3'd6) &&
                   (md_src0 == {1'b1, {(WIDTH-1){1'b0}}}) && (md_src1 == '1);
        fast     = md_op[2] ? (fz1 | fovf) : (fz1 | (md_src0 == '0));
        fast_res = '0;
        if (md_op[2]) begin
            if (fz1)
                fast_res = md_op[1] ? md_src0 : '1;
            else
                fast_res = md_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`endif

    // Next-state and datapath update; flush always wins back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        src0_d  = src0_q;
        dvs_d   = dvs_q;
        acc_d   = acc_q;
        negq_d  = negq_q;
        nega_d  = nega_q;
        div0_d  = div0_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = md_op;
                    src0_d  = md_src0;
                    dvs_d   = mag1;
                    acc_d   = {{WIDTH{1'b0}}, mag0};
                    negq_d  = neg0 ^ neg1;
                    nega_d  = neg0;
                    div0_d  = (md_src1 == '0);
                    cnt_d   = CW'(WIDTH);
                    state_d = CALC;
`ifdef MULDIV_FAST_PATH_EN
                    if (fast) begin
                        cnt_d   = '0;
                        res_d   = fast_res;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = step_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    res_d   = finish_res(op_q, step_nxt, negq_q, nega_q, div0_q, src0_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // State and datapath registers, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            src0_q  <= '0;
            dvs_q   <= '0;
            acc_q   <= '0;
            negq_q  <= 1'b0;
            nega_q  <= 1'b0;
            div0_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            src0_q  <= src0_d;
            dvs_q   <= dvs_d;
            acc_q   <= acc_d;
            negq_q  <= negq_d;
            nega_q  <= nega_d;
            div0_q  <= div0_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign md_res    = res_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and small random testbench for mul_div_unit (WIDTH=32).
// Latency is counted with the acceptance cycle as cycle 0.
module tb_mul_div_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_PATH_EN
    localparam int ZL = 1;
`else
    localparam int ZL = W + 1;
`endif
    localparam int NL = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   md_op = '0;
    logic [W-1:0] md_src0 = '0, md_src1 = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] md_res;

    int n_chk = 0;
    int n_fail = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .md_op(md_op), .md_src0(md_src0), .md_src1(md_src1), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .md_res(md_res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference results from wide native arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Issue one request, wait for the result, optionally stall the consumer.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input int stall);
        int lat;
        check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; md_op = op; md_src0 = a; md_src1 = b;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (exp_lat > 0) check({tag, "/lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "/res"}, 64'(md_res), 64'(exp));
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            check({tag, "/hold_res"}, 64'(md_res), 64'(exp));
            check({tag, "/hold_vr"}, 64'({out_valid, in_ready}), 64'b10);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "/after_hs"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 20));
            2: return 32'h0 - 32'($urandom_range(1, 20));
            default: begin
                case ($urandom_range(0, 4))
                    0: return 32'h0;
                    1: return 32'h1;
                    2: return 32'hFFFFFFFF;
                    3: return 32'h80000000;
                    default: return 32'h7FFFFFFF;
                endcase
            end
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        #2;
        check("reset_vr", 64'({out_valid, in_ready}), 64'b01);
        check("reset_res", 64'(md_res), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Arithmetic vectors
        run_op("mul_7x-3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, NL, 0);
        run_op("mul_lo",       3'd0, 32'h12345678, 32'h10,       32'h23456780, NL, 0);
        run_op("mulhu_ff",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NL, 0);
        run_op("mulhsu_m1x2",  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, NL, 0);
        run_op("mulhsu_min",   3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, NL, 0);
        run_op("mulh_min",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, NL, 0);
        run_op("mulh_2p32",    3'd1, 32'h40000000, 32'd4,        32'h00000001, NL, 0);
        run_op("mulh_neg",     3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, NL, 0);
        run_op("div_-7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NL, 0);
        run_op("rem_-7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, NL, 0);
        run_op("div_7_-2",     3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, NL, 0);
        run_op("rem_7_-2",     3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, NL, 0);
        run_op("divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14,       NL, 0);
        run_op("remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,        NL, 0);

        // Boundary cases, shortened when the fast path is built in
        run_op("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, ZL, 0);
        run_op("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, ZL, 0);
        run_op("divu_5_0",     3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, ZL, 0);
        run_op("remu_5_0",     3'd7, 32'd5,        32'd0,        32'd5,        ZL, 0);
        run_op("div_-5_0",     3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, ZL, 0);
        run_op("rem_-5_0",     3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, ZL, 0);
        run_op("mul_0x5",      3'd0, 32'd0,        32'd5,        32'd0,        ZL, 0);

        // Consumer stall in DONE
        run_op("stall10",      3'd5, 32'd1000,     32'd3,        32'd333,      NL, 10);

        // Flush during the fifth CALC cycle
        in_valid = 1'b1; md_op = 3'd5; md_src0 = 32'd100; md_src1 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", 64'({out_valid, in_ready}), 64'b01);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_res", 64'(seen), 64'd0);
        run_op("post_flush",   3'd0, 32'd6,        32'd7,        32'd42,       NL, 0);

        // Asynchronous reset in the middle of CALC
        in_valid = 1'b1; md_op = 3'd0; md_src0 = 32'd123; md_src1 = 32'd456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("rst_mid_vr", 64'({out_valid, in_ready}), 64'b01);
        check("rst_mid_res", 64'(md_res), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op("post_rst",     3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, NL, 0);

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, ref_md(rop, ra, rb), 0,
                   int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
